// File: rtl/envelope_mixer_if.sv
// Control/audio bundle between the sequencer/synth side and envelope_mixer.
// Signal names match the original flat ports so existing hookups map one-to-one.
interface envelope_mixer_if #(
    parameter int NCH = 4
);
    logic [NCH-1:0]   wave_in;
    logic [NCH-1:0]   key_on;
    logic [4*NCH-1:0] decay_rate;
    logic             mute;
    logic             buzzerout;

    modport master (
        output wave_in,
        output key_on,
        output decay_rate,
        output mute,
        input  buzzerout
    );

    modport slave (
        input  wave_in,
        input  key_on,
        input  decay_rate,
        input  mute,
        output buzzerout
    );
endinterface

// File: rtl/envelope_mixer.sv
// Per-channel decaying envelopes, weighted mix of channel waveouts, and a
// first-order sigma-delta modulator producing the 1-bit buzzer output.
module envelope_mixer #(
    parameter int NCH     = 4,
    parameter int ENV_W   = 16,
    parameter int ENV_DIV = 50000
) (
    input  logic              baseclk,
    input  logic              asyncrst_n,
    envelope_mixer_if.slave   mix
);
    localparam int SUM_W = 4 + $clog2(NCH);
    localparam int ACC_W = SUM_W + 1;
    localparam logic [ACC_W-1:0] FS = ACC_W'(15 * NCH);

    logic [ENV_W-1:0] tick_q, tick_d;
    logic             env_tick;
    logic [3:0]       env_q [NCH];
    logic [3:0]       env_d [NCH];
    logic [3:0]       dc_q  [NCH];
    logic [3:0]       dc_d  [NCH];
    logic [3:0]       rate  [NCH];
    logic [SUM_W-1:0] sum_q, sum_d;
    logic [ACC_W-1:0] acc_q, acc_d, acc_t;
    logic             buzz_q, buzz_d;

    always_comb begin
        env_tick = (tick_q == ENV_W'(ENV_DIV - 1));
        tick_d   = env_tick ? '0 : tick_q + 1'b1;
    end

    // key_on beats a coincident tick; the decay counter is not advanced then.
    always_comb begin
        for (int unsigned i = 0; i < NCH; i++) begin
            rate[i]  = mix.decay_rate[4*i +: 4];
            env_d[i] = env_q[i];
            dc_d[i]  = dc_q[i];
            if (mix.key_on[i]) begin
                env_d[i] = 4'd15;
                dc_d[i]  = '0;
            end else if (env_tick && (rate[i] != '0)) begin
                if (dc_q[i] == rate[i] - 4'd1) begin
                    dc_d[i] = '0;
                    if (env_q[i] != '0) begin
                        env_d[i] = env_q[i] - 4'd1;
                    end
                end else begin
                    dc_d[i] = dc_q[i] + 4'd1;
                end
            end
        end
    end

    // Mix uses the envelopes as registered before this cycle's update.
    always_comb begin
        sum_d = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (mix.wave_in[i]) begin
                sum_d = sum_d + SUM_W'(env_q[i]);
            end
        end
        if (mix.mute) begin
            sum_d = '0;
        end
    end

    // acc stays below FS, so acc + sum never exceeds ACC_W bits.
    always_comb begin
        acc_t = acc_q + ACC_W'(sum_q);
        if (acc_t >= FS) begin
            acc_d  = acc_t - FS;
            buzz_d = 1'b1;
        end else begin
            acc_d  = acc_t;
            buzz_d = 1'b0;
        end
    end

    always_ff @(posedge baseclk or negedge asyncrst_n) begin
        if (!asyncrst_n) begin
            tick_q <= '0;
            sum_q  <= '0;
            acc_q  <= '0;
            buzz_q <= 1'b0;
            for (int unsigned i = 0; i < NCH; i++) begin
                env_q[i] <= '0;
                dc_q[i]  <= '0;
            end
        end else begin
            tick_q <= tick_d;
            sum_q  <= sum_d;
            acc_q  <= acc_d;
            buzz_q <= buzz_d;
            for (int unsigned i = 0; i < NCH; i++) begin
                env_q[i] <= env_d[i];
                dc_q[i]  <= dc_d[i];
            end
        end
    end

    assign mix.buzzerout = buzz_q;

endmodule

// File: tb/tb_envelope_mixer.sv
// Bench for envelope_mixer (NCH=4, ENV_DIV=4): vector table plus hand sequences,
// with a per-cycle expected-output queue fed by a behavioural envelope/mixer model.
module tb_envelope_mixer;
    localparam int NCH = 4;
    localparam int DIV = 4;
    localparam int FS  = 15 * NCH;

    logic clk;
    logic rst_n;

    envelope_mixer_if #(.NCH(NCH)) bus ();

    envelope_mixer #(
        .NCH    (NCH),
        .ENV_W  (16),
        .ENV_DIV(DIV)
    ) dut (
        .baseclk   (clk),
        .asyncrst_n(rst_n),
        .mix       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  wave;
        logic [3:0]  key;
        logic [15:0] decay;
        logic        mute;
        int          ncyc;
        int          ones;
    } vec_t;

    vec_t vecs [7];

    int menv [NCH];
    int mdc  [NCH];
    int mtick;
    int macc;
    bit exp_q [$];

    int checks   = 0;
    int failures = 0;

    task automatic chk_bit(input string name, input logic act, input logic expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, expv, $time);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    task automatic model_clear();
        for (int ch = 0; ch < NCH; ch++) begin
            menv[ch] = 0;
            mdc[ch]  = 0;
        end
        mtick = 0;
        macc  = 0;
        exp_q.delete();
        exp_q.push_back(1'b0);
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        bus.wave_in    = '0;
        bus.key_on     = '0;
        bus.decay_rate = '0;
        bus.mute       = 1'b0;
        #3;
        chk_bit("reset_out", bus.buzzerout, 1'b0);
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Drive one cycle; the output bit these inputs produce is due one edge later.
    task automatic step(input logic [3:0] w, input logic [3:0] k, input logic [15:0] d,
                        input logic m, output logic obs);
        int  s;
        int  t;
        int  r;
        bit  tick;
        bit  eb;
        bus.wave_in    = w;
        bus.key_on     = k;
        bus.decay_rate = d;
        bus.mute       = m;
        s = 0;
        for (int ch = 0; ch < NCH; ch++) begin
            if (w[ch]) s += menv[ch];
        end
        if (m) s = 0;
        t = macc + s;
        eb = (t >= FS);
        macc = eb ? t - FS : t;
        exp_q.push_back(eb);
        tick  = (mtick == DIV - 1);
        mtick = (mtick + 1) % DIV;
        for (int ch = 0; ch < NCH; ch++) begin
            r = int'(d[4*ch +: 4]);
            if (k[ch]) begin
                menv[ch] = 15;
                mdc[ch]  = 0;
            end else if (tick && r != 0) begin
                if (mdc[ch] == r - 1) begin
                    mdc[ch] = 0;
                    if (menv[ch] > 0) menv[ch] = menv[ch] - 1;
                end else begin
                    mdc[ch] = (mdc[ch] + 1) % 16;
                end
            end
        end
        @(posedge clk);
        #1;
        obs = bus.buzzerout;
        chk_bit("scoreboard", obs, exp_q.pop_front());
    endtask

    initial begin
        logic o;
        int   ones;

        vecs[0] = '{wave:4'hF, key:4'h0, decay:16'h0000, mute:1'b0, ncyc:100, ones:0};
        vecs[1] = '{wave:4'h1, key:4'h1, decay:16'h0000, mute:1'b0, ncyc:100, ones:24};
        vecs[2] = '{wave:4'hF, key:4'hF, decay:16'h0000, mute:1'b0, ncyc:100, ones:98};
        vecs[3] = '{wave:4'h1, key:4'h1, decay:16'h0002, mute:1'b0, ncyc:200, ones:15};
        vecs[4] = '{wave:4'h2, key:4'h2, decay:16'h0010, mute:1'b0, ncyc:100, ones:7};
        vecs[5] = '{wave:4'hF, key:4'hF, decay:16'h0000, mute:1'b1, ncyc:50,  ones:0};
        vecs[6] = '{wave:4'h3, key:4'hF, decay:16'h0000, mute:1'b0, ncyc:100, ones:49};

        rst_n = 1'b0;
        for (int v = 0; v < 7; v++) begin
            do_reset();
            ones = 0;
            step(vecs[v].wave, vecs[v].key, vecs[v].decay, vecs[v].mute, o);
            ones += int'(o);
            for (int c = 1; c < vecs[v].ncyc; c++) begin
                step(vecs[v].wave, 4'h0, vecs[v].decay, vecs[v].mute, o);
                ones += int'(o);
            end
            chk_int($sformatf("vec%0d_ones", v), ones, vecs[v].ones);
        end

        // key_on on ch0 exactly on the edge that would decrement it
        do_reset();
        ones = 0;
        for (int c = 1; c <= 40; c++) begin
            step(4'h1, (c == 1 || c == 16) ? 4'h1 : 4'h0, 16'h0002, 1'b0, o);
            ones += int'(o);
        end
        chk_int("keyon_tick_ones", ones, 9);

        // full-scale mix, mute/unmute latency, then reset mid-note
        do_reset();
        step(4'hF, 4'hF, 16'h0, 1'b0, o);
        for (int c = 0; c < 9; c++) step(4'hF, 4'h0, 16'h0, 1'b0, o);
        chk_bit("fullscale", o, 1'b1);
        step(4'hF, 4'h0, 16'h0, 1'b1, o);
        chk_bit("mute_lat1", o, 1'b1);
        step(4'hF, 4'h0, 16'h0, 1'b1, o);
        chk_bit("mute_lat2", o, 1'b0);
        for (int c = 0; c < 5; c++) step(4'hF, 4'h0, 16'h0, 1'b1, o);
        chk_bit("mute_hold", o, 1'b0);
        step(4'hF, 4'h0, 16'h0, 1'b0, o);
        chk_bit("unmute_lat1", o, 1'b0);
        step(4'hF, 4'h0, 16'h0, 1'b0, o);
        chk_bit("unmute_lat2", o, 1'b1);
        for (int c = 0; c < 3; c++) step(4'hF, 4'h0, 16'h0, 1'b0, o);
        rst_n = 1'b0;
        #1;
        chk_bit("async_reset", bus.buzzerout, 1'b0);
        do_reset();
        ones = 0;
        for (int c = 0; c < 20; c++) begin
            step(4'hF, 4'h0, 16'h0, 1'b0, o);
            ones += int'(o);
        end
        chk_int("post_reset_silent", ones, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
